exu_div_ctime_ctl: RTL
======================

# exu_div_ctime_ctl

Parametrised constant-latency divide wrapper for the EXU, used to make divide timing analysable for MBPTA. It instantiates the existing `exu_div_ctl` core and captures the core's result whenever it arrives. The result is released with a `finish` pulse exactly `LATENCY` cycles after issue, independent of operand values or the small-number fast path. An optional compile-time LFSR adds randomised padding to the latency, and the block flags any configuration where the core outruns the window.

## Interface
Parameters:
- `LATENCY`, 36: fixed cycles from `dp.valid` to `finish`. Legal range is ≥ 2. The core's worst-case finish is cycle 34.
- `PAD_W`, 3: width of the random pad (0 … 2^PAD_W−1 extra cycles). Only used when the macro is defined.
- `CNT_W`, derived as `$clog2(LATENCY + 2**PAD_W) + 1`: width of the cycle counter.

Ports:
- `clk`  in  1  single clock. Drives all flops and the inner core.
- `rst_l`  in  1  reset, asynchronous, active-low.
- `scan_mode`  in  1  scan mode, passed through to the core.
- `dec_tlu_fast_div_disable`  in  1  passed through to the core.
- `dividend`  in  32  numerator.
- `divisor`  in  32  denominator.
- `dp`  in  div_pkt_t  valid/unsign/rem.
- `flush_lower`  in  1  pipeline flush, passed through to the core.
- `valid_ff_e1`  out  1  passed through from the core.
- `finish_early`  out  1  tied 0; every result is delivered through the fixed-latency path.
- `finish`  out  1  one-cycle result pulse.
- `div_stall`  out  1  divide in progress.
- `out`  out  32  result. Held until the next `finish`.
- `overrun`  out  1  sticky: the core finished after the target cycle.

## Operation
- FSM has three states: IDLE, RUN, WAIT.
- **IDLE → RUN** on `dp.valid && !flush_lower`. The issue cycle is cycle 0.
  - At issue, load target `T` (`LATENCY`, plus pad if the macro is defined) and clear the counter.
  - `dp.valid` while not in IDLE is illegal. The block ignores it and does not forward it to the core.
- **RUN**:
  - Counter increments each cycle; it reads k at cycle k.
  - When the core asserts `finish` or `finish_early`, latch the core's `out` into `res_q` and set `res_vld`.
  - At cycle T with `res_vld`, or with the core finishing in that same cycle (bypass, no extra cycle): assert `finish`, update `out`, return to IDLE.
  - At cycle T with no result available: go to WAIT and set `overrun` (sticky).
- **WAIT**: on the core's finish, assert `finish` that same cycle, update `out`, return to IDLE.
- **Flush**: `flush_lower` in RUN or WAIT aborts the divide.
  - Next state is IDLE. `finish` is not asserted and `out` is unchanged.
  - Clear `res_vld`; the core is flushed by the same signal.
- **`div_stall`** is high in RUN and WAIT, including the `finish` cycle. It is low in IDLE.
- **Arithmetic**:
  - Counter is unsigned `CNT_W` bits and never wraps; T < 2^CNT_W−1 by construction.
  - Divide-by-zero and overflow results are whatever the core produces.
- **Reset** (any time, including mid-operation):
  - State IDLE; counter, `res_q`, `res_vld` cleared.
  - Outputs: `out`=0, `finish`=0, `div_stall`=0, `overrun`=0, `finish_early`=0, `valid_ff_e1`=0.
  - LFSR is reseeded.

## Timing
- Issue at cycle 0.
- `div_stall` high from cycle 1 through cycle T.
- `finish` and the new `out` value appear together at cycle T; `out` is registered and holds thereafter.
- `div_stall` is low at T+1. Earliest next issue is cycle T+1, giving back-to-back throughput of one divide per T+1 cycles.
- Overrun case: `finish` occurs at the core's finish cycle k > T, and `overrun` rises at cycle T+1.
- Flush at cycle j: `div_stall` is low at j+1, and a new issue is accepted at j+1.

## Configuration
- `EXU_DIV_CTIME_RAND_PAD_EN` defined:
  - 16-bit Fibonacci LFSR, taps 16/14/13/11, seed 16'hACE1 on reset.
  - LFSR advances every cycle.
  - At issue, T = `LATENCY` + `lfsr[PAD_W-1:0]`.
- Macro undefined:
  - No LFSR is instantiated.
  - T = `LATENCY` always; `PAD_W` only sizes `CNT_W`.

## Test plan
- `LATENCY`=36, macro off, unsigned 100/7 issued at cycle 0 -> `finish` exactly at cycle 36, `out`=14, `div_stall` high cycles 1–36, `overrun`=0.
- Fast path: 6/3, `dec_tlu_fast_div_disable`=0 -> `finish` still at cycle 36, `out`=2, `finish_early` never 1. Repeat with disable=1 -> identical timing.
- Signed rem: −7 % 2 -> `out`=32'hFFFF_FFFF at cycle 36. Then 0x8000_0000 / 0xFFFF_FFFF signed -> `out` matches the core's result at cycle 36.
- Flush: issue 1000/3, `flush_lower` at cycle 10 -> no `finish`, `div_stall` low at cycle 11, `out` keeps its previous value. A new 9/3 issued at cycle 11 finishes at cycle 47 with `out`=3.
- `LATENCY`=20 instance, 0xFFFF_FFFF/1 unsigned -> `finish` at the core's finish cycle (>20), `overrun` high from cycle 21 and still high after a later normal divide.
- Macro on, `PAD_W`=3: eight back-to-back divides -> each `finish` at 36 + `lfsr[2:0]` sampled at issue, always within cycles 36–43. Assert `rst_l`=0 mid-divide -> all outputs 0 at once, and no `finish` after release.

Source files
------------

// File: rtl/exu_div_ctime_ctl.sv
// ============================================================================
// exu_div_ctime_ctl -- constant-latency divide wrapper for the EXU
//
// Wraps the exu_div_ctl core so every divide completes exactly LATENCY cycles
// after issue (cycle 0), regardless of operand values or the core's
// small-number fast path.  The core result is captured when it arrives and is
// released with a one-cycle `finish` pulse at the target cycle.  If the core
// has not delivered by then, the wrapper waits for it and sets the sticky
// `overrun` flag.
//
// Optional feature macro: EXU_DIV_CTIME_RAND_PAD_EN
//   When defined, a 16-bit Fibonacci LFSR (taps 16/14/13/11, seed 16'hACE1)
//   adds 0..2**PAD_W-1 random cycles of padding to the target at each issue.
//
// Ports:
//   clk, rst_l                 clock, asynchronous active-low reset
//   scan_mode                  passed to the core
//   dec_tlu_fast_div_disable   disables the core's small-number fast path
//   dividend, divisor          32-bit operands
//   dp                         divide packet (valid / unsign / rem)
//   flush_lower                aborts an in-flight divide
//   valid_ff_e1                core's registered valid
//   finish_early               always 0
//   finish                     one-cycle result pulse at the target cycle
//   div_stall                  high while a divide is in progress
//   out                        result, held until the next finish
//   overrun                    sticky: core finished after the target cycle
//
// File also contains exu_div_pkg (div_pkt_t) and the exu_div_ctl core.
// ============================================================================

package exu_div_pkg;
    typedef struct packed {
        logic valid;
        logic unsign;
        logic rem;
    } div_pkt_t;
endpackage

// ----------------------------------------------------------------------------
// exu_div_ctl -- radix-2 restoring divider core
//   Full path: issue at cycle 0, 32 iterations in cycles 1..32, sign fix-up in
//   cycle 33, `finish` at cycle 34.  Fast path (both magnitudes < 256, nonzero
//   divisor, not disabled): `finish_early` at cycle 1.
//   Divide-by-zero: quotient all ones, remainder = dividend.  Signed overflow
//   (0x8000_0000 / -1): quotient 0x8000_0000, remainder 0.
// ----------------------------------------------------------------------------
module exu_div_ctl
    import exu_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst_l,
    input  logic        scan_mode,
    input  logic        dec_tlu_fast_div_disable,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  div_pkt_t    dp,
    input  logic        flush_lower,
    output logic        valid_ff_e1,
    output logic        finish_early,
    output logic        finish,
    output logic        div_stall,
    output logic [31:0] out
);
    logic        busy, fast, neg_q, neg_r, want_rem, dvz;
    logic [5:0]  cnt;
    logic [31:0] rem_r, quo_r, dvs_r, dvd_r, res_r;
    logic [31:0] abs_a, abs_b;
    logic [7:0]  q8, r8;
    logic [32:0] rem_sh, diff;
    logic        start, fast_ok;
    logic        unused_scan;

    assign unused_scan = scan_mode;

    function automatic logic [31:0] fixup(input logic [31:0] q, input logic [31:0] r,
                                          input logic nq, input logic nr, input logic rm);
        if (rm) return nr ? -r : r;
        return nq ? -q : q;
    endfunction

    assign start   = dp.valid && !flush_lower && !busy;
    assign abs_a   = (!dp.unsign && dividend[31]) ? -dividend : dividend;
    assign abs_b   = (!dp.unsign && divisor[31])  ? -divisor  : divisor;
    assign fast_ok = !dec_tlu_fast_div_disable && (abs_b != '0) &&
                     (abs_a[31:8] == '0) && (abs_b[31:8] == '0);
    assign q8      = (abs_b[7:0] == '0) ? '0 : abs_a[7:0] / abs_b[7:0];
    assign r8      = (abs_b[7:0] == '0) ? '0 : abs_a[7:0] % abs_b[7:0];

    always_comb begin
        rem_sh = {rem_r, quo_r[31]};
        diff   = rem_sh - {1'b0, dvs_r};
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            busy        <= 1'b0;
            fast        <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            want_rem    <= 1'b0;
            dvz         <= 1'b0;
            cnt         <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            dvs_r       <= '0;
            dvd_r       <= '0;
            res_r       <= '0;
            valid_ff_e1 <= 1'b0;
        end else begin
            valid_ff_e1 <= dp.valid && !flush_lower;
            if (flush_lower) begin
                busy <= 1'b0;
            end else if (start) begin
                busy     <= 1'b1;
                cnt      <= 6'd1;
                fast     <= fast_ok;
                rem_r    <= '0;
                quo_r    <= abs_a;
                dvs_r    <= abs_b;
                dvd_r    <= dividend;
                dvz      <= (divisor == '0);
                neg_q    <= !dp.unsign && (dividend[31] ^ divisor[31]);
                neg_r    <= !dp.unsign && dividend[31];
                want_rem <= dp.rem;
                if (fast_ok)
                    res_r <= fixup({24'd0, q8}, {24'd0, r8},
                                   !dp.unsign && (dividend[31] ^ divisor[31]),
                                   !dp.unsign && dividend[31], dp.rem);
            end else if (busy) begin
                if (fast || cnt == 6'd34) begin
                    busy <= 1'b0;
                end else begin
                    if (cnt <= 6'd32) begin
                        if (!diff[32]) begin
                            rem_r <= diff[31:0];
                            quo_r <= {quo_r[30:0], 1'b1};
                        end else begin
                            rem_r <= rem_sh[31:0];
                            quo_r <= {quo_r[30:0], 1'b0};
                        end
                    end else begin
                        res_r <= dvz ? (want_rem ? dvd_r : '1)
                                     : fixup(quo_r, rem_r, neg_q, neg_r, want_rem);
                    end
                    cnt <= cnt + 6'd1;
                end
            end
        end
    end

    assign finish       = busy && !fast && (cnt == 6'd34);
    assign finish_early = busy && fast;
    assign div_stall    = busy;
    assign out          = res_r;
endmodule

// ----------------------------------------------------------------------------
// exu_div_ctime_ctl -- fixed-latency wrapper
// ----------------------------------------------------------------------------
module exu_div_ctime_ctl
    import exu_div_pkg::*;
#(
    parameter int LATENCY = 36,
    parameter int PAD_W   = 3,
    parameter int CNT_W   = $clog2(LATENCY + 2**PAD_W) + 1
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        scan_mode,
    input  logic        dec_tlu_fast_div_disable,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  div_pkt_t    dp,
    input  logic        flush_lower,
    output logic        valid_ff_e1,
    output logic        finish_early,
    output logic        finish,
    output logic        div_stall,
    output logic [31:0] out,
    output logic        overrun
);
    typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, tgt, tgt_issue;
    logic [31:0]        res_q, out_q, res_sel, core_out;
    logic               res_vld, overrun_q;
    logic               issue, fin, set_ov, latch;
    logic               core_finish, core_finish_early, core_done;
    logic               unused_core_stall;
    div_pkt_t           core_dp;

    assign issue = (state == IDLE) && dp.valid && !flush_lower;

    // A packet arriving while busy is dropped rather than handed to the core.
    always_comb begin
        core_dp       = dp;
        core_dp.valid = dp.valid && (state == IDLE);
    end

    exu_div_ctl u_core (
        .clk                      (clk),
        .rst_l                    (rst_l),
        .scan_mode                (scan_mode),
        .dec_tlu_fast_div_disable (dec_tlu_fast_div_disable),
        .dividend                 (dividend),
        .divisor                  (divisor),
        .dp                       (core_dp),
        .flush_lower              (flush_lower),
        .valid_ff_e1              (valid_ff_e1),
        .finish_early             (core_finish_early),
        .finish                   (core_finish),
        .div_stall                (unused_core_stall),
        .out                      (core_out)
    );

    assign core_done = core_finish || core_finish_early;

`ifdef EXU_DIV_CTIME_RAND_PAD_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign tgt_issue = CNT_W'(LATENCY) + CNT_W'(lfsr[PAD_W-1:0]);
`else
    assign tgt_issue = CNT_W'(LATENCY);
`endif

    always_comb begin
        state_nxt = state;
        fin       = 1'b0;
        res_sel   = res_q;
        set_ov    = 1'b0;
        latch     = 1'b0;
        case (state)
            IDLE: if (issue) state_nxt = RUN;
            RUN: begin
                if (flush_lower) begin
                    state_nxt = IDLE;
                end else if (cnt == tgt) begin
                    if (res_vld) begin
                        fin       = 1'b1;
                        state_nxt = IDLE;
                    end else if (core_done) begin
                        // core landing exactly on the target cycle is bypassed
                        fin       = 1'b1;
                        res_sel   = core_out;
                        state_nxt = IDLE;
                    end else begin
                        set_ov    = 1'b1;
                        state_nxt = WAIT;
                    end
                end else if (core_done) begin
                    latch = 1'b1;
                end
            end
            WAIT: begin
                if (flush_lower) begin
                    state_nxt = IDLE;
                end else if (core_done) begin
                    fin       = 1'b1;
                    res_sel   = core_out;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state     <= IDLE;
            cnt       <= '0;
            tgt       <= '0;
            res_q     <= '0;
            res_vld   <= 1'b0;
            out_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state <= state_nxt;
            // Loaded with 1 at issue so the counter reads k during cycle k.
            if (issue) begin
                cnt     <= CNT_W'(1);
                tgt     <= tgt_issue;
                res_vld <= 1'b0;
            end else if (state == RUN) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (latch) begin
                res_q   <= core_out;
                res_vld <= 1'b1;
            end
            if (state != IDLE && state_nxt == IDLE)
                res_vld <= 1'b0;
            if (fin)
                out_q <= res_sel;
            if (set_ov)
                overrun_q <= 1'b1;
        end
    end

    // The new result is visible in the finish cycle itself and held after it.
    assign out          = fin ? res_sel : out_q;
    assign finish       = fin;
    assign finish_early = 1'b0;
    assign div_stall    = (state != IDLE);
    assign overrun      = overrun_q;
endmodule
